spc700_addr_seq: RTL and testbench



---
 rtl/spc700_addr_seq.sv | 203 ++++++++++++++++++++
 tb/tb_spc700_addr_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spc700_addr_seq.sv
// ---------------------------------------------------------------------------
// spc700_addr_seq
// Addressing-mode sequencer for the SPC700 address generator.
// The decoder hands over one addressing mode through a START/DONE handshake.
// The sequencer then walks through the mode's steps. On each step it drives
// the generator's ADDR_CTRL and LOAD_PC controls and picks the bus address
// source (PC or AX). A step advances only on cycles where EN=1.
//
// Ports:
//   CLK, RST_N   core clock; synchronous active-low reset
//   EN           core clock enable (a step executes only when EN=1)
//   START/MODE   request strobe and addressing mode (MODE latched on accept)
//   TAKEN        branch condition, sampled while mode 9 executes step 0
//   BUSY/DONE    sequence in progress / one-cycle completion pulse
//   ERR          qualifies DONE when the mode was reserved (12-15)
//   ADDR_CTRL    {AL ctrl, AH ctrl, mux select} to the address generator
//   LOAD_PC      PC load select to the address generator
//   BUS_SEL      0 = bus address is PC, 1 = bus address is AX
//   STEP         current step index (debug)
// ---------------------------------------------------------------------------
module spc700_addr_seq #(
    parameter logic B2B = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       START,
    input  logic [3:0] MODE,
    input  logic       TAKEN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [5:0] ADDR_CTRL,
    output logic [2:0] LOAD_PC,
    output logic       BUS_SEL,
    output logic [2:0] STEP
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Step control words: {BUS_SEL, LOAD_PC[2:0], ADDR_CTRL[5:0]}
    localparam logic [9:0] C_DP  = 10'b0_001_100100; // AL<=D_IN, AH<=P
    localparam logic [9:0] C_IX  = 10'b0_000_010000; // AL<=AL+X (page wrap)
    localparam logic [9:0] C_IY  = 10'b0_000_010001; // AL<=AL+Y (page wrap)
    localparam logic [9:0] C_AL  = 10'b0_001_100000; // AL<=D_IN
    localparam logic [9:0] C_AH  = 10'b0_001_001000; // AH<=D_IN
    localparam logic [9:0] C_HC  = 10'b0_000_001100; // AH<=AH+carry
    localparam logic [9:0] C_P1  = 10'b1_000_110000; // pointer lo read, AL+1
    localparam logic [9:0] C_PX  = 10'b1_000_011010; // AL<=DR, AH<=D_IN
    localparam logic [9:0] C_PY  = 10'b1_000_011011; // AL<=DR+Y, AH<=D_IN
    localparam logic [9:0] C_F0  = 10'b0_001_000000; // operand fetch only
    localparam logic [9:0] C_JP  = 10'b0_010_000000; // PC<={D_IN,DR}
    localparam logic [9:0] C_BR  = 10'b0_011_000000; // PC<=PC+sext(DR)
    localparam logic [9:0] C_I16 = 10'b1_000_111100; // 16-bit AX+1
    localparam logic [9:0] C_JI  = 10'b1_010_000000; // PC<={D_IN,DR} via AX
    localparam logic [9:0] C_PC  = 10'b0_101_000000; // PC<={FF,AL}

    function automatic logic is_rsvd(input logic [3:0] m);
        return m[3] & m[2];
    endfunction

    // Index of the final step. For mode 9 this is the taken path; the
    // not-taken exit is handled separately at step 0.
    function automatic logic [2:0] last_step(input logic [3:0] m);
        case (m)
            4'd0:                      return 3'd0;
            4'd4, 4'd5, 4'd6, 4'd7:    return 3'd3;
            4'd10:                     return 3'd5;
            default:                   return 3'd1;
        endcase
    endfunction

    function automatic logic [9:0] step_ctrl(input logic [3:0] m, input logic [2:0] s);
        logic [9:0] c;
        c = '0;
        case (m)
            4'd0: c = C_DP;
            4'd1: c = (s == 3'd0) ? C_DP : C_IX;
            4'd2: c = (s == 3'd0) ? C_DP : C_IY;
            4'd3: c = (s == 3'd0) ? C_AL : C_AH;
            4'd4, 4'd5, 4'd10: begin
                case (s)
                    3'd0:    c = C_AL;
                    3'd1:    c = C_AH;
                    3'd2:    c = (m == 4'd5) ? C_IY : C_IX;
                    3'd3:    c = C_HC;
                    3'd4:    c = C_I16;
                    default: c = C_JI;
                endcase
            end
            4'd6: begin
                case (s)
                    3'd0:    c = C_DP;
                    3'd1:    c = C_IX;
                    3'd2:    c = C_P1;
                    default: c = C_PX;
                endcase
            end
            4'd7: begin
                case (s)
                    3'd0:    c = C_DP;
                    3'd1:    c = C_P1;
                    3'd2:    c = C_PY;
                    default: c = C_HC;
                endcase
            end
            4'd8:  c = (s == 3'd0) ? C_F0 : C_JP;
            4'd9:  c = (s == 3'd0) ? C_F0 : C_BR;
            4'd11: c = (s == 3'd0) ? C_AL : C_PC;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] mode_q,  mode_d;
    logic [2:0] step_q,  step_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;
    logic [9:0] ctrl_q,  ctrl_d;
    logic [2:0] stepo_q, stepo_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (START && EN) begin
                    state_d = RUN;
                    mode_d  = MODE;
                    step_d  = '0;
                end
            end
            RUN: begin
                if (EN) begin
                    if (is_rsvd(mode_q)) begin
                        state_d = FIN;
                    end else if (mode_q == 4'd9 && step_q == 3'd0) begin
                        // The branch outcome is held as the step index: only
                        // the taken path ever reaches step 1.
                        if (TAKEN) step_d  = 3'd1;
                        else       state_d = FIN;
                    end else if (step_q == last_step(mode_q)) begin
                        state_d = FIN;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (B2B && START && EN) begin
                    state_d = RUN;
                    mode_d  = MODE;
                    step_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered and computed from the next-state values.
        // They depend only on the sequencer state, never directly on the
        // inputs.
        busy_d  = (state_d == RUN);
        done_d  = (state_d == FIN);
        err_d   = done_d && is_rsvd(mode_d);
        ctrl_d  = busy_d ? step_ctrl(mode_d, step_d) : '0;
        stepo_d = busy_d ? step_d : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            mode_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ctrl_q  <= '0;
            stepo_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
            stepo_q <= stepo_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign BUS_SEL   = ctrl_q[9];
    assign LOAD_PC   = ctrl_q[8:6];
    assign ADDR_CTRL = ctrl_q[5:0];
    assign STEP      = stepo_q;

endmodule

// File: tb/tb_spc700_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_spc700_addr_seq
// Directed vectors for spc700_addr_seq. Each record holds the inputs for one
// clock cycle and the outputs expected after that cycle's edge. A second
// instance with B2B=0 covers the idle cycle that gets inserted between
// back-to-back requests.
// ---------------------------------------------------------------------------
module tb_spc700_addr_seq;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0, en = 1'b0, start = 1'b0, taken = 1'b0;
    logic [3:0] mode = 4'd0;

    logic       busy1, done1, err1, bsel1, busy0, done0, err0, bsel0;
    logic [5:0] ac1, ac0;
    logic [2:0] lpc1, st1, lpc0, st0;

    always #5 CLK = ~CLK;

    spc700_addr_seq #(.B2B(1'b1)) dut1 (
        .CLK(CLK), .RST_N(rst_n), .EN(en), .START(start), .MODE(mode), .TAKEN(taken),
        .BUSY(busy1), .DONE(done1), .ERR(err1), .ADDR_CTRL(ac1), .LOAD_PC(lpc1),
        .BUS_SEL(bsel1), .STEP(st1));

    spc700_addr_seq #(.B2B(1'b0)) dut0 (
        .CLK(CLK), .RST_N(rst_n), .EN(en), .START(start), .MODE(mode), .TAKEN(taken),
        .BUSY(busy0), .DONE(done0), .ERR(err0), .ADDR_CTRL(ac0), .LOAD_PC(lpc0),
        .BUS_SEL(bsel0), .STEP(st0));

    // observed = {BUSY, DONE, ERR, BUS_SEL, LOAD_PC, ADDR_CTRL, STEP}
    wire [15:0] obs1 = {busy1, done1, err1, bsel1, lpc1, ac1, st1};
    wire [15:0] obs0 = {busy0, done0, err0, bsel0, lpc0, ac0, st0};

    typedef struct {
        string      name;
        logic       rst, en, st, tk;
        logic [3:0] mode;
        logic [15:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // fl = {BUSY, DONE, ERR}; ctl = {BUS_SEL, LOAD_PC, ADDR_CTRL}
    task automatic v(input string nm, input logic r, input logic e, input logic s,
                     input logic [3:0] m, input logic tk, input logic [2:0] fl,
                     input logic [9:0] ctl, input logic [2:0] stp);
        vec_t x;
        x.name = nm; x.rst = r; x.en = e; x.st = s; x.mode = m; x.tk = tk;
        x.exp  = {fl, ctl, stp};
        vq.push_back(x);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk0(input string nm, input logic [15:0] exp);
        n_tests++;
        if (obs0 !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", nm, obs0, exp);
        end
    endtask

    localparam logic [2:0] IDL = 3'b000, BSY = 3'b100, DN = 3'b010, DNE = 3'b011;

    initial begin
        // reset
        v("rst0", 0,1,0,4'd0,0, IDL, 10'b0, 3'd0);
        v("rst1", 0,1,1,4'd4,0, IDL, 10'b0, 3'd0);
        // mode 4 abs+X, START re-asserted while busy must be ignored
        v("m4 s0",  1,1,1,4'd4, 0,BSY, 10'b0_001_100000, 3'd0);
        v("m4 s1",  1,1,1,4'd13,0,BSY, 10'b0_001_001000, 3'd1);
        v("m4 s2",  1,1,1,4'd13,0,BSY, 10'b0_000_010000, 3'd2);
        v("m4 s3",  1,1,1,4'd13,0,BSY, 10'b0_000_001100, 3'd3);
        v("m4 dn",  1,1,0,4'd0, 0,DN,  10'b0, 3'd0);
        v("m4 idl", 1,1,0,4'd0, 0,IDL, 10'b0, 3'd0);
        // mode 9 not taken
        v("m9n s0",  1,1,1,4'd9,0,BSY, 10'b0_001_000000, 3'd0);
        v("m9n dn",  1,1,0,4'd0,0,DN,  10'b0, 3'd0);
        v("m9n idl", 1,1,0,4'd0,0,IDL, 10'b0, 3'd0);
        // mode 9 taken
        v("m9t s0",  1,1,1,4'd9,0,BSY, 10'b0_001_000000, 3'd0);
        v("m9t s1",  1,1,0,4'd0,1,BSY, 10'b0_011_000000, 3'd1);
        v("m9t dn",  1,1,0,4'd0,0,DN,  10'b0, 3'd0);
        v("m9t idl", 1,1,0,4'd0,0,IDL, 10'b0, 3'd0);
        // mode 7 with EN gaps: outputs frozen while EN=0
        v("m7 s0",   1,1,1,4'd7,0,BSY, 10'b0_001_100100, 3'd0);
        v("m7 f0a",  1,0,1,4'd0,0,BSY, 10'b0_001_100100, 3'd0);
        v("m7 f0b",  1,0,0,4'd0,0,BSY, 10'b0_001_100100, 3'd0);
        v("m7 s1",   1,1,0,4'd0,0,BSY, 10'b1_000_110000, 3'd1);
        v("m7 f1a",  1,0,0,4'd0,0,BSY, 10'b1_000_110000, 3'd1);
        v("m7 f1b",  1,0,1,4'd2,0,BSY, 10'b1_000_110000, 3'd1);
        v("m7 s2",   1,1,0,4'd0,0,BSY, 10'b1_000_011011, 3'd2);
        v("m7 f2",   1,0,0,4'd0,0,BSY, 10'b1_000_011011, 3'd2);
        v("m7 s3",   1,1,0,4'd0,0,BSY, 10'b0_000_001100, 3'd3);
        v("m7 f3",   1,0,0,4'd0,0,BSY, 10'b0_000_001100, 3'd3);
        v("m7 dn",   1,1,0,4'd0,0,DN,  10'b0, 3'd0);
        v("m7 idl",  1,1,0,4'd0,0,IDL, 10'b0, 3'd0);
        // reserved mode 13
        v("m13 run", 1,1,1,4'd13,0,BSY, 10'b0, 3'd0);
        v("m13 dn",  1,1,0,4'd0, 0,DNE, 10'b0, 3'd0);
        v("m13 idl", 1,1,0,4'd0, 0,IDL, 10'b0, 3'd0);
        // back-to-back, START held high: mode 0 then mode 8, no idle gap
        v("b2b m0",  1,1,1,4'd0,0,BSY, 10'b0_001_100100, 3'd0);
        v("b2b dn0", 1,1,1,4'd8,0,DN,  10'b0, 3'd0);
        v("b2b m8a", 1,1,1,4'd8,0,BSY, 10'b0_001_000000, 3'd0);
        v("b2b m8b", 1,1,0,4'd0,0,BSY, 10'b0_010_000000, 3'd1);
        v("b2b dn8", 1,1,0,4'd0,0,DN,  10'b0, 3'd0);
        v("b2b idl", 1,1,0,4'd0,0,IDL, 10'b0, 3'd0);
        // mode 2 dp+Y
        v("m2 s0",  1,1,1,4'd2,0,BSY, 10'b0_001_100100, 3'd0);
        v("m2 s1",  1,1,0,4'd0,0,BSY, 10'b0_000_010001, 3'd1);
        v("m2 dn",  1,1,0,4'd0,0,DN,  10'b0, 3'd0);
        // mode 11 pcall
        v("m11 s0", 1,1,1,4'd11,0,BSY, 10'b0_001_100000, 3'd0);
        v("m11 s1", 1,1,0,4'd0, 0,BSY, 10'b0_101_000000, 3'd1);
        v("m11 dn", 1,1,0,4'd0, 0,DN,  10'b0, 3'd0);
        // mode 10 full run
        v("m10 s0", 1,1,1,4'd10,0,BSY, 10'b0_001_100000, 3'd0);
        v("m10 s1", 1,1,0,4'd0, 0,BSY, 10'b0_001_001000, 3'd1);
        v("m10 s2", 1,1,0,4'd0, 0,BSY, 10'b0_000_010000, 3'd2);
        v("m10 s3", 1,1,0,4'd0, 0,BSY, 10'b0_000_001100, 3'd3);
        v("m10 s4", 1,1,0,4'd0, 0,BSY, 10'b1_000_111100, 3'd4);
        v("m10 s5", 1,1,0,4'd0, 0,BSY, 10'b1_010_000000, 3'd5);
        v("m10 dn", 1,1,0,4'd0, 0,DN,  10'b0, 3'd0);
        // mode 10 aborted by reset in s2: no DONE afterwards
        v("ab s0",  1,1,1,4'd10,0,BSY, 10'b0_001_100000, 3'd0);
        v("ab s1",  1,1,0,4'd0, 0,BSY, 10'b0_001_001000, 3'd1);
        v("ab s2",  1,1,0,4'd0, 0,BSY, 10'b0_000_010000, 3'd2);
        v("ab rst", 0,1,0,4'd0, 0,IDL, 10'b0, 3'd0);
        v("ab nd1", 1,1,0,4'd0, 0,IDL, 10'b0, 3'd0);
        v("ab nd2", 1,1,0,4'd0, 0,IDL, 10'b0, 3'd0);

        foreach (vq[i]) begin
            rst_n = vq[i].rst; en = vq[i].en; start = vq[i].st;
            mode  = vq[i].mode; taken = vq[i].tk;
            tick();
            n_tests++;
            if (obs1 !== vq[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d %s got %h exp %h", i, vq[i].name, obs1, vq[i].exp);
            end
        end

        // B2B=0: START held high across DONE inserts one idle cycle
        rst_n = 1'b0; en = 1'b1; start = 1'b0; mode = 4'd0; taken = 1'b0;
        tick();
        chk0("nb2b rst", {IDL, 10'b0, 3'd0});
        rst_n = 1'b1; start = 1'b1; mode = 4'd0;
        tick();
        chk0("nb2b m0", {BSY, 10'b0_001_100100, 3'd0});
        mode = 4'd8;
        tick();
        chk0("nb2b dn0", {DN, 10'b0, 3'd0});
        tick();
        chk0("nb2b gap", {IDL, 10'b0, 3'd0});
        tick();
        chk0("nb2b m8a", {BSY, 10'b0_001_000000, 3'd0});
        start = 1'b0;
        tick();
        chk0("nb2b m8b", {BSY, 10'b0_010_000000, 3'd1});
        tick();
        chk0("nb2b dn8", {DN, 10'b0, 3'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
